operand_fetch_unit: RTL

- Reader-side client of the 8-bit processor's register bank.
- Accepts a decoded instruction's register fields, drives the bank's two read addresses and captures the two operands.
- Bypasses same-edge writeback data that the bank has not yet returned.
- Presents the operands downstream with a valid/ready handshake; sits between decode and execute.

---
 rtl/operand_fetch_unit_pkg.sv | 11 +
 rtl/operand_fetch_unit_bypass.sv | 25 ++
 rtl/operand_fetch_unit.sv | 113 +++++++++++
 3 files changed

// File: rtl/operand_fetch_unit_pkg.sv
// Shared widths and FSM state encoding for the operand fetch unit.
package operand_fetch_unit_pkg;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    VALID = 2'd2
  } state_t;
endpackage

// File: rtl/operand_fetch_unit_bypass.sv
// Next-operand selection: bank data or held operand, overridden by a matching writeback.
// R0_ZERO_EN forces operand 0 whenever the source index is 0.
module operand_bypass #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 3
) (
  input  logic [ADDR_W-1:0] SrcIdx,
  input  logic [DATA_W-1:0] BankData,
  input  logic [DATA_W-1:0] HeldOp,
  input  logic              WbWrite,
  input  logic [ADDR_W-1:0] WbReg,
  input  logic [DATA_W-1:0] WbData,
  input  logic              SelBank,
  output logic [DATA_W-1:0] NextOp
);
  logic [DATA_W-1:0] base;

  always_comb begin
    base   = SelBank ? BankData : HeldOp;
    NextOp = (WbWrite && (WbReg == SrcIdx)) ? WbData : base;
`ifdef R0_ZERO_EN
    if (SrcIdx == '0) NextOp = '0;
`endif
  end
endmodule

// File: rtl/operand_fetch_unit.sv
// Register-bank read client: latches source indices, captures operands with
// same-edge writeback bypass, and hands them downstream via valid/ready.
// Optional macro: R0_ZERO_EN (register 0 reads as zero).
module operand_fetch_unit
  import operand_fetch_unit_pkg::*;
#(
  parameter int unsigned DATA_W = operand_fetch_unit_pkg::DATA_W,
  parameter int unsigned ADDR_W = operand_fetch_unit_pkg::ADDR_W
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              InstrValid,
  output logic              InstrReady,
  input  logic [ADDR_W-1:0] Rs1,
  input  logic [ADDR_W-1:0] Rs2,
  input  logic [ADDR_W-1:0] Rd,
  output logic [ADDR_W-1:0] RegLido1,
  output logic [ADDR_W-1:0] RegLido2,
  input  logic [DATA_W-1:0] Dado1,
  input  logic [DATA_W-1:0] Dado2,
  input  logic              WbWrite,
  input  logic [ADDR_W-1:0] WbReg,
  input  logic [DATA_W-1:0] WbData,
  output logic              OpValid,
  input  logic              OpReady,
  output logic [DATA_W-1:0] OpA,
  output logic [DATA_W-1:0] OpB,
  output logic [ADDR_W-1:0] OpRd
);
  state_t            state;
  logic [ADDR_W-1:0] srcA, srcB, dstLatched;
  logic [DATA_W-1:0] nextA, nextB;
  logic              selBank;

  assign selBank = (state == FETCH);

  operand_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bypassA (
    .SrcIdx(srcA), .BankData(Dado1), .HeldOp(OpA),
    .WbWrite(WbWrite), .WbReg(WbReg), .WbData(WbData),
    .SelBank(selBank), .NextOp(nextA)
  );

  operand_bypass #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bypassB (
    .SrcIdx(srcB), .BankData(Dado2), .HeldOp(OpB),
    .WbWrite(WbWrite), .WbReg(WbReg), .WbData(WbData),
    .SelBank(selBank), .NextOp(nextB)
  );

  // Gated by Reset so the block never advertises readiness while held in reset.
  always_comb begin
    InstrReady = 1'b0;
    case (state)
      IDLE:    InstrReady = Reset;
      VALID:   InstrReady = Reset & OpReady;
      default: InstrReady = 1'b0;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state      <= IDLE;
      srcA       <= '0;
      srcB       <= '0;
      dstLatched <= '0;
      RegLido1   <= '0;
      RegLido2   <= '0;
      OpValid    <= 1'b0;
      OpA        <= '0;
      OpB        <= '0;
      OpRd       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (InstrValid) begin
            srcA       <= Rs1;
            srcB       <= Rs2;
            dstLatched <= Rd;
            RegLido1   <= Rs1;
            RegLido2   <= Rs2;
            state      <= FETCH;
          end
        end
        FETCH: begin
          OpA     <= nextA;
          OpB     <= nextB;
          OpRd    <= dstLatched;
          OpValid <= 1'b1;
          state   <= VALID;
        end
        VALID: begin
          if (OpReady) begin
            OpValid <= 1'b0;
            if (InstrValid) begin
              srcA       <= Rs1;
              srcB       <= Rs2;
              dstLatched <= Rd;
              RegLido1   <= Rs1;
              RegLido2   <= Rs2;
              state      <= FETCH;
            end else begin
              state <= IDLE;
            end
          end else begin
            // Held operands track writebacks to their source registers.
            OpA <= nextA;
            OpB <= nextB;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
